bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter built on the shift-and-add-3 (double-dabble) algorithm. It is the clocked companion to the combinational divider/modulo converter. It replaces the K-stage chain of `/10` and `%10` with one shared add-3 column that is sequenced over 4K cycles. It sits between a binary counter/ALU result and the seven-segment digit drivers, and uses a start/busy/done handshake.

## Interface
Parameters:
- `K`, default 2: number of BCD output digits. The binary input width is 4K bits. Legal range is 1..8.

Ports:
- `clk`, input, 1: system clock, rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: conversion request. Sampled on the rising edge.
- `bin`, input, 4K: unsigned binary operand. Captured in the cycle `start` is accepted.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse. Marks the cycle in which `bcd` and `ovf` are updated.
- `bcd`, output, 4K: K packed BCD digits, least significant digit in [3:0]. Holds its value between conversions.
- `ovf`, output, 1: high when `bin` ≥ 10^K, meaning `bcd` holds `bin` mod 10^K.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - `start`=1: load the `bin` shift register, clear the BCD work register and the sticky carry, set the counter to 4K, go to CONV.
  - Otherwise stay in IDLE.
- CONV, one iteration per cycle:
  - Each work digit ≥5 gets +3, all digits in parallel.
  - The work register is then shifted left by 1. The MSB of the `bin` shift register enters bit 0.
  - The bit shifted out of the top digit ORs into the sticky carry.
  - The counter decrements. When the counter reaches 0 after a shift, go to DONE.
- DONE:
  - Copy the work register to `bcd` and the sticky carry to `ovf`. Pulse `done`.
  - `start`=1: accept a new operand exactly as in IDLE and go to CONV. This gives back-to-back operation.
  - Otherwise go to IDLE.
- Arithmetic: only K digits are kept. Dropping the carry out of the top digit yields `bin` mod 10^K. Any dropped 1 means the true value ≥ 10^K.
- `start` while in CONV is ignored. It is not queued, and `bin` is not re-sampled.
- `bin` may change freely after the accept cycle.

## Timing
- Reset values:
  - state is IDLE
  - `busy`=0
  - `done`=0
  - `bcd`=0
  - `ovf`=0
  - internal counter and work registers are 0.
- Reset mid-conversion aborts immediately: no `done` pulse, and `bcd`/`ovf` return to 0.
- Latency: with `start` accepted at edge N, `done`=1 and `bcd`/`ovf` are valid in the cycle after edge N+4K. K=2 gives 9 cycles start-to-done.
- `busy` is 1 in every CONV cycle. It is 0 in IDLE and DONE.
- Back-to-back throughput is one conversion per 4K+1 cycles.
- `done` and `busy` are both registered outputs. `bcd` changes only on the edge that enters DONE.

## Configuration
- `BIN2BCD_OVF_EN` defined: the sticky-carry register and `ovf` behave as specified above.
- `BIN2BCD_OVF_EN` undefined:
  - The sticky-carry logic is removed and `ovf` is tied to 0.
  - `bcd` still equals `bin` mod 10^K.
  - Latency and handshake are unchanged.

## Test plan
- K=2, `bin`=8'd42, one-cycle `start`: `busy` is high for 8 cycles, then `done` pulses with `bcd`=8'h42 and `ovf`=0. `bcd` holds 8'h42 afterwards.
- K=2, sweep `bin`=0, 9, 10, 99, 100, 255:
  - `bcd` = 8'h00, 8'h09, 8'h10, 8'h99, 8'h00, 8'h55.
  - `ovf` = 0, 0, 0, 0, 1, 1.
  - Run again with `BIN2BCD_OVF_EN` undefined: `ovf` is always 0.
- K=2, `start` with `bin`=8'd77, then `start` pulses with `bin`=8'd12 during CONV: the result is 8'h77, a single `done` pulse, and no second conversion starts.
- K=2, `start` held high continuously with `bin` alternating 8'd123 and 8'd5 at each accept: `done` pulses every 9 cycles with `bcd`=8'h23 (ovf=1), then 8'h05 (ovf=0).
- K=2, `rst` asserted 4 cycles into converting 8'd200: outputs are 0 immediately, with no `done`. A new `start` with 8'd64 gives 8'h64 after 9 cycles.
- K=4, `bin`=16'd65535: `done` arrives 17 cycles after `start`, with `bcd`=16'h5535 and `ovf`=1. With `bin`=16'd9999: `bcd`=16'h9999 and `ovf`=0.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, start/busy/done.
// Define BIN2BCD_OVF_EN to keep the sticky overflow flag; otherwise ovf_o is tied low.
module bin2bcd_seq #(
  parameter int unsigned K = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [4*K-1:0] bin_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [4*K-1:0] bcd_o,
  output logic           ovf_o
);

  localparam int unsigned W    = 4 * K;
  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            accept;
  logic [W-1:0]    adj;
  logic [3:0]      dig;
  // Bit W is the carry shifted out of the top digit.
  logic [W:0]      shifted;
  logic            last;

  always_comb begin
    adj = '0;
    dig = '0;
    for (int unsigned i = 0; i < K; i++) begin
      dig = work_q[4*i +: 4];
      adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
  end

  assign shifted = {adj, sh_q[W-1]};
  assign last    = (cnt_q == CntW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: accept = start_i;
      StConv: begin
        work_d = shifted[W-1:0];
        sh_d   = {sh_q[W-2:0], 1'b0};
        cnt_d  = cnt_q - CntW'(1);
        if (last) begin
          state_d = StDone;
          bcd_d   = shifted[W-1:0];
          done_d  = 1'b1;
        end
      end
      StDone: begin
        accept  = start_i;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      state_d = StConv;
      sh_d    = bin_i;
      work_d  = '0;
      cnt_d   = CntW'(W);
    end
    busy_d = (state_d == StConv);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BIN2BCD_OVF_EN
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;

  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      carry_d = 1'b0;
    end else if (state_q == StConv) begin
      carry_d = carry_q | shifted[W];
      if (last) ovf_d = carry_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_msb;
  assign unused_msb = shifted[W];
  assign ovf_o      = 1'b0;
`endif

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: one K=2 and one K=4 instance sharing clock and reset.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start2 = 1'b0, start4 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic [15:0] bin4 = '0;
  logic        busy2, done2, ovf2, busy4, done4, ovf4;
  logic [7:0]  bcd2;
  logic [15:0] bcd4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.K(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .bin_i(bin2),
    .busy_o(busy2), .done_o(done2), .bcd_o(bcd2), .ovf_o(ovf2)
  );

  bin2bcd_seq #(.K(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .bin_i(bin4),
    .busy_o(busy4), .done_o(done4), .bcd_o(bcd4), .ovf_o(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start, then wait for done. lat counts edges after the accept edge.
  task automatic run_conv(input bit wide, input logic [15:0] b, output logic [15:0] r,
                          output logic o, output int lat, output int busy_n);
    if (wide) begin start4 = 1'b1; bin4 = b; end
    else begin start2 = 1'b1; bin2 = b[7:0]; end
    tick();
    start2 = 1'b0;
    start4 = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!(wide ? done4 : done2) && lat < 60) begin
      if (wide ? busy4 : busy2) busy_n++;
      tick();
      lat++;
    end
    r = wide ? bcd4 : {8'h00, bcd2};
    o = wide ? ovf4 : ovf2;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({busy2, done2, bcd2, ovf2} !== 11'd0) begin
      failures++;
      $display("FAIL reset_k2 got busy=%b done=%b bcd=%h ovf=%b want all 0", busy2, done2, bcd2,
               ovf2);
    end
    checks++;
    if ({busy4, done4, bcd4, ovf4} !== 19'd0) begin
      failures++;
      $display("FAIL reset_k4 got busy=%b done=%b bcd=%h ovf=%b want all 0", busy4, done4, bcd4,
               ovf4);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] r;
    logic o;
    int lat, bn;
    run_conv(1'b0, 16'd42, r, o, lat, bn);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++;
    if (bn !== 8) begin failures++; $display("FAIL basic_busy_cycles got %0d want 8", bn); end
    checks++;
    if (r[7:0] !== 8'h42 || o !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got bcd=%h ovf=%b want 42/0", r[7:0], o);
    end
    tick();
    tick();
    tick();
    checks++;
    if (bcd2 !== 8'h42 || done2 !== 1'b0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold got bcd=%h done=%b busy=%b want 42/0/0", bcd2, done2, busy2);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] vin [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
    logic [7:0] vbcd[6] = '{8'h00, 8'h09, 8'h10, 8'h99, 8'h00, 8'h55};
    bit         vovf[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] r;
    logic o;
    int lat, bn;
    for (int i = 0; i < 6; i++) begin
      run_conv(1'b0, {8'h00, vin[i]}, r, o, lat, bn);
      checks++;
      if (lat !== 8 || r[7:0] !== vbcd[i] || o !== (vovf[i] & OvfEn)) begin
        failures++;
        $display("FAIL sweep_%0d got lat=%0d bcd=%h ovf=%b want lat=8 bcd=%h ovf=%b", vin[i],
                 lat, r[7:0], o, vbcd[i], vovf[i] & OvfEn);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int dn = 0, bn = 0;
    logic [7:0] res = '0;
    for (int c = 0; c < 30; c++) begin
      start2 = (c == 0 || c == 3 || c == 5);
      bin2   = (c == 0) ? 8'd77 : 8'd12;
      tick();
      if (done2) begin dn++; res = bcd2; end
      if (busy2) bn++;
    end
    start2 = 1'b0;
    checks++;
    if (dn !== 1 || res !== 8'h77) begin
      failures++;
      $display("FAIL ignore_start got dones=%0d bcd=%h want 1/77", dn, res);
    end
    checks++;
    if (bn !== 8) begin failures++; $display("FAIL ignore_busy got %0d want 8", bn); end
  endtask

  task automatic test_back_to_back();
    int dn = 0;
    start2 = 1'b1;
    for (int k = 0; k < 36; k++) begin
      bin2 = ((k / 9) % 2 == 0) ? 8'd123 : 8'd5;
      tick();
      if (done2) begin
        dn++;
        checks++;
        if (k % 9 != 8) begin
          failures++;
          $display("FAIL b2b_timing got done at edge %0d want edge%%9==8", k);
        end else if ((k / 9) % 2 == 0 ? (bcd2 !== 8'h23 || ovf2 !== OvfEn)
                                      : (bcd2 !== 8'h05 || ovf2 !== 1'b0)) begin
          failures++;
          $display("FAIL b2b_result edge %0d got bcd=%h ovf=%b", k, bcd2, ovf2);
        end
      end
    end
    start2 = 1'b0;
    checks++;
    if (dn !== 4) begin failures++; $display("FAIL b2b_count got %0d want 4", dn); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic o;
    int lat, bn, dn = 0;
    start2 = 1'b1;
    bin2 = 8'd200;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy2, done2, bcd2, ovf2} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b bcd=%h ovf=%b want all 0", busy2, done2, bcd2,
               ovf2);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 2) rst = 1'b0;
      tick();
      if (done2) dn++;
    end
    checks++;
    if (dn !== 0) begin failures++; $display("FAIL reset_mid_done got %0d want 0", dn); end
    run_conv(1'b0, 16'd64, r, o, lat, bn);
    checks++;
    if (lat !== 8 || r[7:0] !== 8'h64 || o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_next got lat=%0d bcd=%h ovf=%b want 8/64/0", lat, r[7:0], o);
    end
  endtask

  task automatic test_k4();
    logic [15:0] r;
    logic o;
    int lat, bn;
    run_conv(1'b1, 16'd65535, r, o, lat, bn);
    checks++;
    if (lat !== 16 || bn !== 16 || r !== 16'h5535 || o !== OvfEn) begin
      failures++;
      $display("FAIL k4_65535 got lat=%0d busy=%0d bcd=%h ovf=%b want 16/16/5535/%b", lat, bn, r,
               o, OvfEn);
    end
    tick();
    run_conv(1'b1, 16'd9999, r, o, lat, bn);
    checks++;
    if (lat !== 16 || r !== 16'h9999 || o !== 1'b0) begin
      failures++;
      $display("FAIL k4_9999 got lat=%0d bcd=%h ovf=%b want 16/9999/0", lat, r, o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_k4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
